// File: rtl/vdp_vram_arb_pkg.sv
// Shared types for the VDP VRAM arbiter:
// FSM states, port ids and the latched request.
package vdp_vram_arb_pkg;

  localparam int ADDR_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD
  } state_e;

  localparam logic [1:0] PORT_SCR = 2'd0;
  localparam logic [1:0] PORT_CPU = 2'd1;
  localparam logic [1:0] PORT_CMD = 2'd2;

  typedef struct packed {
    logic [1:0]        port;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } req_t;

  // 1 = byte not written; only the addressed lane is enabled
  function automatic logic [3:0] lane_mask(
    input logic [1:0] a
  );
    return ~(4'b0001 << a);
  endfunction

endpackage

// File: rtl/vdp_vram_arb_select.sv
// Winner selection: screen first, then the
// round-robin pick between cpu and cmd.
module vdp_vram_arb_select (
  input  logic       scr_valid,
  input  logic       cpu_valid,
  input  logic       cmd_valid,
  input  logic       ptr_cmd,
  output logic [2:0] grant
);

  // grant is one-hot {cmd, cpu, scr}
  always_comb begin
    grant = 3'b000;
    if (scr_valid) begin
      grant = 3'b001;
    end else if (cpu_valid && cmd_valid) begin
      grant = ptr_cmd ? 3'b100 : 3'b010;
    end else if (cpu_valid) begin
      grant = 3'b010;
    end else if (cmd_valid) begin
      grant = 3'b100;
    end
  end

endmodule

// File: rtl/vdp_vram_arbiter.sv
// Single-outstanding VRAM arbiter between screen,
// cpu and command engine, with byte-lane steering.
module vdp_vram_arbiter
  import vdp_vram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              scr_valid,
  output logic              scr_ready,
  input  logic [ADDR_W-1:0] scr_address,
  output logic [31:0]       scr_rdata,
  output logic              scr_rdata_en,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rdata_en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [7:0]        cmd_wdata,
  output logic [7:0]        cmd_rdata,
  output logic              cmd_rdata_en,
  output logic              sdram_valid,
  input  logic              sdram_ready,
  output logic              sdram_write,
  output logic [ADDR_W-3:0] sdram_address,
  output logic [31:0]       sdram_wdata,
  output logic [3:0]        sdram_wdata_mask,
  input  logic [31:0]       sdram_rdata,
  input  logic              sdram_rdata_en
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        ptr_q, ptr_d;
  logic [31:0] scr_rdata_q, scr_rdata_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  cmd_rdata_q, cmd_rdata_d;
  logic [2:0]  en_q, en_d;
  logic [2:0]  grant;
  logic        idle;
  logic [7:0]  lane;

  vdp_vram_arb_select u_sel (
    .scr_valid (scr_valid),
    .cpu_valid (cpu_valid),
    .cmd_valid (cmd_valid),
    .ptr_cmd   (ptr_q),
    .grant     (grant)
  );

  assign idle      = (state_q == ST_IDLE);
  assign scr_ready = idle & grant[0];
  assign cpu_ready = idle & grant[1];
  assign cmd_ready = idle & grant[2];

  assign sdram_valid   = (state_q == ST_ISSUE);
  assign sdram_write   = req_q.write;
  assign sdram_address = req_q.addr[ADDR_W-1:2];
  assign sdram_wdata   = {4{req_q.wdata}};
  assign sdram_wdata_mask =
    req_q.write ? lane_mask(req_q.addr[1:0]) : 4'b0000;

  assign scr_rdata    = scr_rdata_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign cmd_rdata    = cmd_rdata_q;
  assign scr_rdata_en = en_q[0];
  assign cpu_rdata_en = en_q[1];
  assign cmd_rdata_en = en_q[2];

  always_comb begin
    lane = 8'h00;
    unique case (req_q.addr[1:0])
      2'd0: lane = sdram_rdata[7:0];
      2'd1: lane = sdram_rdata[15:8];
      2'd2: lane = sdram_rdata[23:16];
      2'd3: lane = sdram_rdata[31:24];
      default: lane = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ptr_d       = ptr_q;
    scr_rdata_d = scr_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cmd_rdata_d = cmd_rdata_q;
    en_d        = 3'b000;
    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d = ST_ISSUE;
          unique case (1'b1)
            grant[0]: begin
              req_d.port  = PORT_SCR;
              req_d.write = 1'b0;
              req_d.addr  = scr_address;
              req_d.wdata = 8'h00;
            end
            grant[1]: begin
              req_d.port  = PORT_CPU;
              req_d.write = cpu_write;
              req_d.addr  = cpu_address;
              req_d.wdata = cpu_wdata;
              ptr_d       = 1'b1;
            end
            grant[2]: begin
              req_d.port  = PORT_CMD;
              req_d.write = cmd_write;
              req_d.addr  = cmd_address;
              req_d.wdata = cmd_wdata;
              ptr_d       = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        if (sdram_ready) begin
          state_d = req_q.write ? ST_IDLE
                                : ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (sdram_rdata_en) begin
          state_d = ST_IDLE;
          unique case (req_q.port)
            PORT_SCR: begin
              scr_rdata_d = sdram_rdata;
              en_d[0]     = 1'b1;
            end
            PORT_CPU: begin
              cpu_rdata_d = lane;
              en_d[1]     = 1'b1;
            end
            default: begin
              cmd_rdata_d = lane;
              en_d[2]     = 1'b1;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      ptr_q       <= 1'b0;
      scr_rdata_q <= '0;
      cpu_rdata_q <= '0;
      cmd_rdata_q <= '0;
      en_q        <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      ptr_q       <= ptr_d;
      scr_rdata_q <= scr_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cmd_rdata_q <= cmd_rdata_d;
      en_q        <= en_d;
    end
  end

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter: vector
// table for arbitration plus corner sequences.
module tb_vdp_vram_arbiter;
  import vdp_vram_arb_pkg::*;

  logic              clk;
  logic              reset;
  logic              scr_valid, scr_ready;
  logic [ADDR_W-1:0] scr_address;
  logic [31:0]       scr_rdata;
  logic              scr_rdata_en;
  logic              cpu_valid, cpu_ready, cpu_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [7:0]        cpu_wdata, cpu_rdata;
  logic              cpu_rdata_en;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [7:0]        cmd_wdata, cmd_rdata;
  logic              cmd_rdata_en;
  logic              sdram_valid, sdram_ready;
  logic              sdram_write;
  logic [ADDR_W-3:0] sdram_address;
  logic [31:0]       sdram_wdata;
  logic [3:0]        sdram_wdata_mask;
  logic [31:0]       sdram_rdata;
  logic              sdram_rdata_en;
  logic [2:0]        rdy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_en_scr = 0;
  int n_en_cpu = 0;
  int n_en_cmd = 0;
  int s_scr, s_cpu, s_cmd;

  vdp_vram_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .scr_valid        (scr_valid),
    .scr_ready        (scr_ready),
    .scr_address      (scr_address),
    .scr_rdata        (scr_rdata),
    .scr_rdata_en     (scr_rdata_en),
    .cpu_valid        (cpu_valid),
    .cpu_ready        (cpu_ready),
    .cpu_write        (cpu_write),
    .cpu_address      (cpu_address),
    .cpu_wdata        (cpu_wdata),
    .cpu_rdata        (cpu_rdata),
    .cpu_rdata_en     (cpu_rdata_en),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_address      (cmd_address),
    .cmd_wdata        (cmd_wdata),
    .cmd_rdata        (cmd_rdata),
    .cmd_rdata_en     (cmd_rdata_en),
    .sdram_valid      (sdram_valid),
    .sdram_ready      (sdram_ready),
    .sdram_write      (sdram_write),
    .sdram_address    (sdram_address),
    .sdram_wdata      (sdram_wdata),
    .sdram_wdata_mask (sdram_wdata_mask),
    .sdram_rdata      (sdram_rdata),
    .sdram_rdata_en   (sdram_rdata_en)
  );

  assign rdy = {cmd_ready, cpu_ready, scr_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (scr_rdata_en) n_en_scr <= n_en_scr + 1;
    if (cpu_rdata_en) n_en_cpu <= n_en_cpu + 1;
    if (cmd_rdata_en) n_en_cmd <= n_en_cmd + 1;
  end

  typedef struct {
    logic              cpu_v;
    logic              cmd_v;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wd;
    logic [2:0]        exp_rdy;
    logic [3:0]        exp_mask;
    logic [14:0]       exp_word;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, ".rdy"}, 32'(rdy), 0);
    chk({nm, ".sd_valid"}, 32'(sdram_valid), 0);
    chk({nm, ".sd_write"}, 32'(sdram_write), 0);
    chk({nm, ".sd_mask"}, 32'(sdram_wdata_mask), 0);
    chk({nm, ".sd_addr"}, 32'(sdram_address), 0);
    chk({nm, ".sd_wdata"}, sdram_wdata, 0);
    chk({nm, ".scr_rdata"}, scr_rdata, 0);
    chk({nm, ".cpu_rdata"}, 32'(cpu_rdata), 0);
    chk({nm, ".cmd_rdata"}, 32'(cmd_rdata), 0);
    chk({nm, ".en"},
        32'({cmd_rdata_en, cpu_rdata_en,
             scr_rdata_en}), 0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step;
    step;
    reset = 1'b0;
  endtask

  // Called in ISSUE with sdram_ready=1
  task automatic serve_rd(input logic [31:0] d);
    step;
    sdram_rdata_en = 1'b1;
    sdram_rdata    = d;
    step;
    sdram_rdata_en = 1'b0;
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 17'h00000, 8'h11,
                3'b010, 4'b1110, 15'h0000};
    tbl[1]  = '{1'b1, 1'b1, 17'h00001, 8'h22,
                3'b100, 4'b1101, 15'h0000};
    tbl[2]  = '{1'b1, 1'b1, 17'h00002, 8'h33,
                3'b010, 4'b1011, 15'h0000};
    tbl[3]  = '{1'b1, 1'b1, 17'h00003, 8'h44,
                3'b100, 4'b0111, 15'h0000};
    tbl[4]  = '{1'b1, 1'b1, 17'h1FFFF, 8'h55,
                3'b010, 4'b0111, 15'h7FFF};
    tbl[5]  = '{1'b1, 1'b1, 17'h1FFFC, 8'h66,
                3'b100, 4'b1110, 15'h7FFF};
    tbl[6]  = '{1'b1, 1'b1, 17'h10005, 8'h77,
                3'b010, 4'b1101, 15'h4001};
    tbl[7]  = '{1'b1, 1'b1, 17'h0ABCE, 8'h88,
                3'b100, 4'b1011, 15'h2AF3};
    tbl[8]  = '{1'b0, 1'b1, 17'h00004, 8'h99,
                3'b100, 4'b1110, 15'h0001};
    tbl[9]  = '{1'b0, 1'b1, 17'h00009, 8'hAA,
                3'b100, 4'b1101, 15'h0002};
    tbl[10] = '{1'b1, 1'b0, 17'h0000E, 8'hBB,
                3'b010, 4'b1011, 15'h0003};
    tbl[11] = '{1'b1, 1'b0, 17'h0000F, 8'hCC,
                3'b010, 4'b0111, 15'h0003};
    tbl[12] = '{1'b1, 1'b1, 17'h00010, 8'hDD,
                3'b100, 4'b1110, 15'h0004};
    tbl[13] = '{1'b1, 1'b1, 17'h00011, 8'hEE,
                3'b010, 4'b1101, 15'h0004};

    reset = 1'b1;
    scr_valid = 1'b0;
    scr_address = '0;
    cpu_valid = 1'b0;
    cpu_write = 1'b0;
    cpu_address = '0;
    cpu_wdata = '0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_address = '0;
    cmd_wdata = '0;
    sdram_ready = 1'b1;
    sdram_rdata = '0;
    sdram_rdata_en = 1'b0;

    do_reset;
    check_reset("reset");

    // cpu write, single-cycle issue
    cpu_valid = 1'b1;
    cpu_write = 1'b1;
    cpu_address = 17'h00005;
    cpu_wdata = 8'hA5;
    #1;
    chk("wr.rdy", 32'(rdy), 32'b010);
    chk("wr.pre_valid", 32'(sdram_valid), 0);
    step;
    cpu_valid = 1'b0;
    #1;
    chk("wr.valid", 32'(sdram_valid), 1);
    chk("wr.write", 32'(sdram_write), 1);
    chk("wr.addr", 32'(sdram_address), 32'h1);
    chk("wr.wdata", sdram_wdata, 32'hA5A5A5A5);
    chk("wr.mask", 32'(sdram_wdata_mask), 32'b1101);
    chk("wr.rdy_busy", 32'(rdy), 0);
    step;
    chk("wr.valid_end", 32'(sdram_valid), 0);

    // cpu read, data 3 cycles after accept
    cpu_write = 1'b0;
    cpu_valid = 1'b1;
    cpu_address = 17'h00006;
    #1;
    chk("rd.rdy", 32'(rdy), 32'b010);
    step;
    cpu_valid = 1'b0;
    #1;
    chk("rd.valid", 32'(sdram_valid), 1);
    chk("rd.write", 32'(sdram_write), 0);
    chk("rd.mask", 32'(sdram_wdata_mask), 0);
    chk("rd.addr", 32'(sdram_address), 32'h1);
    s_scr = n_en_scr;
    s_cpu = n_en_cpu;
    s_cmd = n_en_cmd;
    step;
    step;
    step;
    sdram_rdata_en = 1'b1;
    sdram_rdata = 32'h44332211;
    #1;
    chk("rd.en_early", 32'(cpu_rdata_en), 0);
    step;
    sdram_rdata_en = 1'b0;
    #1;
    chk("rd.en", 32'(cpu_rdata_en), 1);
    chk("rd.data", 32'(cpu_rdata), 32'h33);
    step;
    chk("rd.en_end", 32'(cpu_rdata_en), 0);
    chk("rd.n_cpu", 32'(n_en_cpu - s_cpu), 1);
    chk("rd.n_scr", 32'(n_en_scr - s_scr), 0);
    chk("rd.n_cmd", 32'(n_en_cmd - s_cmd), 0);

    // three simultaneous reads
    do_reset;
    scr_valid = 1'b1;
    scr_address = 17'h00100;
    cpu_valid = 1'b1;
    cpu_address = 17'h00201;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_address = 17'h00302;
    #1;
    chk("tri.g0", 32'(rdy), 32'b001);
    step;
    scr_valid = 1'b0;
    chk("tri.sd_addr", 32'(sdram_address),
        32'h40);
    serve_rd(32'hDDCCBBAA);
    chk("tri.scr_en", 32'(scr_rdata_en), 1);
    chk("tri.scr_data", scr_rdata, 32'hDDCCBBAA);
    chk("tri.g1", 32'(rdy), 32'b010);
    step;
    cpu_valid = 1'b0;
    serve_rd(32'h44332211);
    chk("tri.cpu_en", 32'(cpu_rdata_en), 1);
    chk("tri.cpu_data", 32'(cpu_rdata), 32'h22);
    chk("tri.g2", 32'(rdy), 32'b100);
    step;
    cmd_valid = 1'b0;
    serve_rd(32'h88776655);
    chk("tri.cmd_en", 32'(cmd_rdata_en), 1);
    chk("tri.cmd_data", 32'(cmd_rdata), 32'h77);
    cpu_write = 1'b1;
    cmd_write = 1'b1;
    cpu_valid = 1'b1;
    cmd_valid = 1'b1;
    #1;
    chk("tri.g3", 32'(rdy), 32'b010);
    step;
    cpu_valid = 1'b0;
    #1;
    chk("tri.g3_valid", 32'(sdram_valid), 1);
    step;
    chk("tri.g4", 32'(rdy), 32'b100);
    step;
    cmd_valid = 1'b0;
    #1;
    chk("tri.g4_valid", 32'(sdram_valid), 1);
    step;

    // round-robin write table
    do_reset;
    cpu_write = 1'b1;
    cmd_write = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cpu_valid = tbl[i].cpu_v;
      cmd_valid = tbl[i].cmd_v;
      cpu_address = tbl[i].addr;
      cmd_address = tbl[i].addr;
      cpu_wdata = tbl[i].wd;
      cmd_wdata = tbl[i].wd;
      #1;
      chk($sformatf("tbl%0d.rdy", i),
          32'(rdy), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d.idle_valid", i),
          32'(sdram_valid), 0);
      step;
      #1;
      chk($sformatf("tbl%0d.valid", i),
          32'(sdram_valid), 1);
      chk($sformatf("tbl%0d.busy_rdy", i),
          32'(rdy), 0);
      chk($sformatf("tbl%0d.addr", i),
          32'(sdram_address),
          32'(tbl[i].exp_word));
      chk($sformatf("tbl%0d.wdata", i),
          sdram_wdata, {4{tbl[i].wd}});
      chk($sformatf("tbl%0d.mask", i),
          32'(sdram_wdata_mask),
          32'(tbl[i].exp_mask));
      step;
    end
    cpu_valid = 1'b0;
    cmd_valid = 1'b0;

    // SDRAM stall during ISSUE
    sdram_ready = 1'b0;
    cpu_valid = 1'b1;
    cpu_address = 17'h00007;
    cpu_wdata = 8'h5A;
    #1;
    chk("stall.rdy", 32'(rdy), 32'b010);
    step;
    cpu_valid = 1'b0;
    scr_valid = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d.valid", i),
          32'(sdram_valid), 1);
      chk($sformatf("stall%0d.addr", i),
          32'(sdram_address), 32'h1);
      chk($sformatf("stall%0d.wdata", i),
          sdram_wdata, 32'h5A5A5A5A);
      chk($sformatf("stall%0d.mask", i),
          32'(sdram_wdata_mask), 32'b0111);
      chk($sformatf("stall%0d.rdy", i),
          32'(rdy), 0);
      step;
    end
    sdram_ready = 1'b1;
    #1;
    chk("stall.hold", 32'(sdram_valid), 1);
    step;
    chk("stall.idle_rdy", 32'(rdy), 32'b001);
    scr_valid = 1'b0;
    cmd_valid = 1'b0;

    // reset while waiting for read data
    cpu_write = 1'b0;
    cpu_valid = 1'b1;
    cpu_address = 17'h00002;
    #1;
    chk("abort.rdy", 32'(rdy), 32'b010);
    step;
    cpu_valid = 1'b0;
    step;
    s_scr = n_en_scr;
    s_cpu = n_en_cpu;
    s_cmd = n_en_cmd;
    reset = 1'b1;
    step;
    reset = 1'b0;
    check_reset("abort");
    step;
    sdram_rdata_en = 1'b1;
    sdram_rdata = 32'hCAFEF00D;
    step;
    sdram_rdata_en = 1'b0;
    #1;
    chk("abort.cpu_en", 32'(cpu_rdata_en), 0);
    chk("abort.cpu_data", 32'(cpu_rdata), 0);
    step;
    chk("abort.n_en",
        32'((n_en_scr - s_scr) +
            (n_en_cpu - s_cpu) +
            (n_en_cmd - s_cmd)), 0);
    cpu_write = 1'b1;
    cpu_valid = 1'b1;
    cpu_address = 17'h00003;
    cpu_wdata = 8'h3C;
    #1;
    chk("abort.next_rdy", 32'(rdy), 32'b010);
    step;
    cpu_valid = 1'b0;
    #1;
    chk("abort.next_valid", 32'(sdram_valid), 1);
    chk("abort.next_mask",
        32'(sdram_wdata_mask), 32'b0111);
    chk("abort.next_wdata",
        sdram_wdata, 32'h3C3C3C3C);
    step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
